// File: rtl/decode_pkg.sv
// Shared encodings for the ID stage: opcodes, write-back selects, ALU ops and the
// registered control bundle that travels with each micro-op.
package decode_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [1:0] MREG_MEM = 2'd0;
    localparam logic [1:0] MREG_ALU = 2'd1;
    localparam logic [1:0] MREG_IMM = 2'd2;
    localparam logic [1:0] MREG_PC1 = 2'd3;

    localparam logic [1:0] MR7_PC1   = 2'd0;
    localparam logic [1:0] MR7_PCIMM = 2'd2;
    localparam logic [1:0] MR7_RF    = 2'd3;

    localparam logic ALU_ADD  = 1'b0;
    localparam logic ALU_NAND = 1'b1;

    // Write enables are active-low, so the idle bundle has them at 1.
    typedef struct packed {
        logic       mex1;
        logic       mex2;
        logic       alu;
        logic [1:0] cz;
        logic       wccr_n;
        logic       wmem_n;
        logic       wrf_n;
        logic       mmem_r;
        logic [1:0] mreg_wb;
        logic [1:0] mr7_wb;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{mex1: 1'b0, mex2: 1'b0, alu: ALU_ADD, cz: 2'b00,
                                   wccr_n: 1'b1, wmem_n: 1'b1, wrf_n: 1'b1, mmem_r: 1'b0,
                                   mreg_wb: MREG_MEM, mr7_wb: MR7_PC1, illegal: 1'b0};

endpackage

// File: rtl/lmsm_seq.sv
// LM/SM expander: walks the register list lowest bit first, one micro-op per step.
//   state  | meaning
//   S_IDLE | no list in flight; k/last are taken from the incoming mask
//   S_SEQ  | remaining bits of an accepted list are held in mask_q
module lmsm_seq #(
    parameter int REG_AW = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      step_i,
    input  logic [(1<<REG_AW)-1:0]    mask_i,
    output logic [REG_AW-1:0]         k_o,
    output logic [REG_AW-1:0]         uop_idx_o,
    output logic                      uop_last_o,
    output logic                      busy_o
);

    localparam int LIST_W = 1 << REG_AW;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEQ  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [LIST_W-1:0] mask_q, mask_d;
    logic [LIST_W-1:0] src;
    logic [LIST_W-1:0] rest;
    logic [REG_AW-1:0] idx_q, idx_d;

    assign busy_o    = (state_q == S_SEQ);
    assign src       = busy_o ? mask_q : mask_i;
    assign uop_idx_o = busy_o ? idx_q : '0;

    always_comb begin
        k_o = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (src[i]) k_o = i[REG_AW-1:0];
        end
    end

    // An empty list also reports last, so it emits a single bubble and stays idle.
    assign rest       = src & ~({{(LIST_W-1){1'b0}}, 1'b1} << k_o);
    assign uop_last_o = (rest == '0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        if (flush_i) begin
            state_d = S_IDLE;
            mask_d  = '0;
            idx_d   = '0;
        end else if (step_i) begin
            if (uop_last_o) begin
                state_d = S_IDLE;
                mask_d  = '0;
                idx_d   = '0;
            end else begin
                state_d = S_SEQ;
                mask_d  = rest;
                idx_d   = uop_idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Registered ID stage: decodes IF/ID into RR control with valid/ready, flush,
// illegal-opcode bubbles and LM/SM expansion into per-register micro-ops.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_ir,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_imm,
    output logic [DATA_W-1:0] sext_imm6,
    output logic [DATA_W-1:0] imm970,
    output logic [REG_AW-1:0] rA1,
    output logic [REG_AW-1:0] rA2,
    output logic [REG_AW-1:0] wA,
    output logic              mex1,
    output logic              mex2,
    output logic              alu_ctrl,
    output logic [1:0]        cz,
    output logic              wCCR,
    output logic              wMem,
    output logic              wRF,
    output logic              mmem_r,
    output logic [1:0]        mreg_wb,
    output logic [1:0]        mr7_wb,
    output logic [REG_AW-1:0] uop_idx,
    output logic              uop_last,
    output logic              illegal
);

    localparam int LIST_W = 1 << REG_AW;

    logic              out_valid_q;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc_out_q, pc_imm_q, pc_imm_d, sext_q, sext_d, imm_q, imm_d;
    logic [DATA_W-1:0] ir_q, pc_q, cur_ir, cur_pc;
    logic [REG_AW-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d, idx_q, idx_d;
    logic [REG_AW-1:0] seq_k, seq_idx;
    logic              last_q, last_d, seq_last, seq_busy;
    logic              load, accept, emit, step, is_lmsm;
    logic [3:0]        op;

    assign load     = !out_valid_q || out_ready;
    assign in_ready = !seq_busy && load && !flush;
    assign accept   = in_valid && in_ready;

    // While a list is in flight the held instruction drives the decoder.
    assign cur_ir  = seq_busy ? ir_q : in_ir;
    assign cur_pc  = seq_busy ? pc_q : in_pc;
    assign op      = cur_ir[15:12];
    assign is_lmsm = (op == OP_LM) || (op == OP_SM);
    assign emit    = seq_busy ? (load && !flush) : accept;
    assign step    = emit && is_lmsm;

    lmsm_seq #(.REG_AW(REG_AW)) u_seq (
        .clk        (clk),
        .rst_n      (reset),
        .flush_i    (flush),
        .step_i     (step),
        .mask_i     (in_ir[LIST_W-1:0]),
        .k_o        (seq_k),
        .uop_idx_o  (seq_idx),
        .uop_last_o (seq_last),
        .busy_o     (seq_busy)
    );

    always_comb begin
        ctrl_d   = CTRL_NOP;
        ra1_d    = '0;
        ra2_d    = '0;
        wa_d     = '0;
        sext_d   = {{(DATA_W-6){cur_ir[5]}}, cur_ir[5:0]};
        imm_d    = {cur_ir[8:0], {(DATA_W-9){1'b0}}};
        pc_imm_d = cur_pc + ((op == OP_JAL) ? {{(DATA_W-9){cur_ir[8]}}, cur_ir[8:0]} : sext_d);
        idx_d    = is_lmsm ? seq_idx : '0;
        last_d   = is_lmsm ? seq_last : 1'b1;
        case (op)
            OP_ADD, OP_NDU: begin
                ra1_d          = cur_ir[11:9];
                ra2_d          = cur_ir[8:6];
                wa_d           = cur_ir[5:3];
                ctrl_d.wrf_n   = 1'b0;
                ctrl_d.wccr_n  = 1'b0;
                ctrl_d.mreg_wb = MREG_ALU;
                ctrl_d.cz      = cur_ir[1:0];
                ctrl_d.alu     = (op == OP_NDU) ? ALU_NAND : ALU_ADD;
            end
            OP_ADI: begin
                ra1_d          = cur_ir[11:9];
                wa_d           = cur_ir[8:6];
                ctrl_d.mex2    = 1'b1;
                ctrl_d.wrf_n   = 1'b0;
                ctrl_d.wccr_n  = 1'b0;
                ctrl_d.mreg_wb = MREG_ALU;
            end
            OP_LHI: begin
                wa_d           = cur_ir[11:9];
                ctrl_d.wrf_n   = 1'b0;
                ctrl_d.mreg_wb = MREG_IMM;
            end
            OP_LW: begin
                ra2_d          = cur_ir[8:6];
                wa_d           = cur_ir[11:9];
                ctrl_d.mex1    = 1'b1;
                ctrl_d.mmem_r  = 1'b1;
                ctrl_d.wrf_n   = 1'b0;
                ctrl_d.wccr_n  = 1'b0;
                ctrl_d.mreg_wb = MREG_MEM;
            end
            OP_SW: begin
                ra1_d         = cur_ir[11:9];
                ra2_d         = cur_ir[8:6];
                ctrl_d.mex1   = 1'b1;
                ctrl_d.wmem_n = 1'b0;
            end
            OP_BEQ: begin
                ra1_d         = cur_ir[11:9];
                ra2_d         = cur_ir[8:6];
                ctrl_d.mr7_wb = MR7_PCIMM;
            end
            OP_JAL: begin
                wa_d           = cur_ir[11:9];
                ctrl_d.wrf_n   = 1'b0;
                ctrl_d.mreg_wb = MREG_PC1;
                ctrl_d.mr7_wb  = MR7_PCIMM;
            end
            OP_JLR: begin
                ra2_d          = cur_ir[8:6];
                wa_d           = cur_ir[11:9];
                ctrl_d.wrf_n   = 1'b0;
                ctrl_d.mreg_wb = MREG_PC1;
                ctrl_d.mr7_wb  = MR7_RF;
            end
            OP_LM, OP_SM: begin
                ra1_d = cur_ir[11:9];
                // Empty list: base register kept, every enable left off.
                if (seq_busy || (cur_ir[LIST_W-1:0] != '0)) begin
                    if (op == OP_LM) begin
                        wa_d           = seq_k;
                        ctrl_d.mmem_r  = 1'b1;
                        ctrl_d.wrf_n   = 1'b0;
                        ctrl_d.mreg_wb = MREG_MEM;
                    end else begin
                        ra2_d         = seq_k;
                        ctrl_d.wmem_n = 1'b0;
                    end
                end
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            pc_out_q    <= '0;
            pc_imm_q    <= '0;
            sext_q      <= '0;
            imm_q       <= '0;
            ra1_q       <= '0;
            ra2_q       <= '0;
            wa_q        <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= emit;
            if (emit) begin
                ctrl_q   <= ctrl_d;
                pc_out_q <= cur_pc;
                pc_imm_q <= pc_imm_d;
                sext_q   <= sext_d;
                imm_q    <= imm_d;
                ra1_q    <= ra1_d;
                ra2_q    <= ra2_d;
                wa_q     <= wa_d;
                idx_q    <= idx_d;
                last_q   <= last_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
            pc_q <= '0;
        end else if (accept) begin
            ir_q <= in_ir;
            pc_q <= in_pc;
        end
    end

    assign out_valid = out_valid_q;
    assign pc_out    = pc_out_q;
    assign pc_imm    = pc_imm_q;
    assign sext_imm6 = sext_q;
    assign imm970    = imm_q;
    assign rA1       = ra1_q;
    assign rA2       = ra2_q;
    assign wA        = wa_q;
    assign mex1      = ctrl_q.mex1;
    assign mex2      = ctrl_q.mex2;
    assign alu_ctrl  = ctrl_q.alu;
    assign cz        = ctrl_q.cz;
    assign wCCR      = ctrl_q.wccr_n;
    assign wMem      = ctrl_q.wmem_n;
    assign wRF       = ctrl_q.wrf_n;
    assign mmem_r    = ctrl_q.mmem_r;
    assign mreg_wb   = ctrl_q.mreg_wb;
    assign mr7_wb    = ctrl_q.mr7_wb;
    assign uop_idx   = idx_q;
    assign uop_last  = last_q;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: an instruction-level model expands each accepted instruction
// into its expected micro-op list; a monitor compares every cycle, plus directed cases.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_pc = 16'h0;
    logic [15:0] in_ir = 16'h0;

    logic        in_ready, out_valid, mex1, mex2, alu_ctrl, wCCR, wMem, wRF, mmem_r;
    logic        uop_last, illegal;
    logic [15:0] pc_out, pc_imm, sext_imm6, imm970;
    logic [2:0]  rA1, rA2, wA, uop_idx;
    logic [1:0]  cz, mreg_wb, mr7_wb;

    decode_pipe #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .pc_out(pc_out), .pc_imm(pc_imm), .sext_imm6(sext_imm6),
        .imm970(imm970), .rA1(rA1), .rA2(rA2), .wA(wA), .mex1(mex1), .mex2(mex2),
        .alu_ctrl(alu_ctrl), .cz(cz), .wCCR(wCCR), .wMem(wMem), .wRF(wRF),
        .mmem_r(mmem_r), .mreg_wb(mreg_wb), .mr7_wb(mr7_wb), .uop_idx(uop_idx),
        .uop_last(uop_last), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc_out;
        logic [15:0] pc_imm;
        logic [15:0] sext;
        logic [15:0] imm970;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wa;
        logic        mex1;
        logic        mex2;
        logic        alu;
        logic [1:0]  cz;
        logic        wccr;
        logic        wmem;
        logic        wrf;
        logic        mmem_r;
        logic [1:0]  mreg;
        logic [1:0]  mr7;
        logic [2:0]  idx;
        logic        last;
        logic        illegal;
    } uop_t;

    uop_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   wa_exp[4] = '{0, 2, 5, 7};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected micro-ops of one instruction, straight from the ISA rules.
    function automatic void push_instr(input logic [15:0] pc, input logic [15:0] ir);
        uop_t       u, v;
        int         s6, s9, total, n;
        logic [3:0] op;
        op = ir[15:12];
        s6 = int'(ir[5:0]);
        if (s6 >= 32) s6 -= 64;
        s9 = int'(ir[8:0]);
        if (s9 >= 256) s9 -= 512;
        u = '0;
        u.pc_out = pc;
        u.sext   = 16'(s6);
        u.pc_imm = 16'(int'(pc) + ((op == 4'h8) ? s9 : s6));
        u.imm970 = 16'(int'(ir[8:0]) * 128);
        u.wccr = 1'b1; u.wmem = 1'b1; u.wrf = 1'b1; u.last = 1'b1;
        case (op)
            4'h0, 4'h2: begin
                u.ra1 = ir[11:9]; u.ra2 = ir[8:6]; u.wa = ir[5:3];
                u.wrf = 0; u.wccr = 0; u.mreg = 1; u.cz = ir[1:0]; u.alu = (op == 4'h2);
            end
            4'h1: begin u.ra1 = ir[11:9]; u.wa = ir[8:6]; u.mex2 = 1; u.wrf = 0; u.wccr = 0; u.mreg = 1; end
            4'h3: begin u.wa = ir[11:9]; u.mreg = 2; u.wrf = 0; end
            4'h4: begin u.ra2 = ir[8:6]; u.wa = ir[11:9]; u.mex1 = 1; u.mmem_r = 1; u.wccr = 0; u.wrf = 0; end
            4'h5: begin u.ra1 = ir[11:9]; u.ra2 = ir[8:6]; u.mex1 = 1; u.wmem = 0; end
            4'hC: begin u.ra1 = ir[11:9]; u.ra2 = ir[8:6]; u.mr7 = 2; end
            4'h8: begin u.wa = ir[11:9]; u.mreg = 3; u.mr7 = 2; u.wrf = 0; end
            4'h9: begin u.ra2 = ir[8:6]; u.wa = ir[11:9]; u.mreg = 3; u.mr7 = 3; u.wrf = 0; end
            4'h6, 4'h7: begin
                u.ra1 = ir[11:9];
                total = $countones(ir[7:0]);
                n = 0;
                if (total == 0) q.push_back(u);
                for (int b = 0; b < 8; b++) begin
                    if (ir[b]) begin
                        v = u;
                        if (op == 4'h6) begin v.wa = 3'(b); v.mmem_r = 1; v.wrf = 0; end
                        else begin v.ra2 = 3'(b); v.wmem = 0; end
                        v.idx  = 3'(n);
                        v.last = (n == total - 1);
                        q.push_back(v);
                        n++;
                    end
                end
                return;
            end
            default: u.illegal = 1'b1;
        endcase
        q.push_back(u);
    endfunction

    function automatic bit model_ready();
        return (q.size() <= 1) && (q.size() == 0 || out_ready) && !flush;
    endfunction

    bit acc;
    always @(posedge clk) begin
        if (!reset || flush) begin
            q.delete();
        end else begin
            acc = in_valid && model_ready();
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) push_instr(in_pc, in_ir);
        end
    end

    uop_t act_u;
    always @(negedge clk) begin
        if (reset) begin
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            chk("in_ready", 128'(in_ready), 128'(model_ready()));
            if (out_valid && q.size() != 0) begin
                act_u = {pc_out, pc_imm, sext_imm6, imm970, rA1, rA2, wA, mex1, mex2, alu_ctrl,
                         cz, wCCR, wMem, wRF, mmem_r, mreg_wb, mr7_wb, uop_idx, uop_last, illegal};
                chk("uop", 128'(act_u), 128'(q[0]));
            end
        end
    end

    task automatic send(input logic [15:0] pc, input logic [15:0] ir);
        bit r;
        r = 1'b0;
        in_pc = pc; in_ir = ir; in_valid = 1'b1;
        for (int n = 0; n < 50 && !r; n++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
        end
        if (!r) chk("accept_timeout", 128'(0), 128'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        int         cnt;
        bit         done;
        logic [3:0] op;
        logic [31:0] rnd;

        // Pin the model against hand-worked values before it is trusted.
        push_instr(16'h0020, 16'h85FF);
        chk("model_jal_pcimm", 128'(q[0].pc_imm), 128'(16'h001F));
        q.delete();
        push_instr(16'h0030, 16'h62A5);
        chk("model_lm_count", 128'(q.size()), 128'(4));
        chk("model_lm_wa2", 128'(q[2].wa), 128'(5));
        chk("model_lm_last", 128'(q[3].last), 128'(1));
        q.delete();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_w_en", 128'({wRF, wMem, wCCR}), 128'(3'b111));
        chk("rst_last", 128'(uop_last), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        send(16'h0010, 16'h0298);
        chk("add_regs", 128'({rA1, rA2, wA}), 128'({3'd1, 3'd2, 3'd3}));
        chk("add_ctrl", 128'({wRF, mreg_wb, cz}), 128'({1'b0, 2'd1, 2'd0}));

        send(16'h0020, 16'h85FF);
        chk("jal_wa", 128'(wA), 128'(2));
        chk("jal_pcimm", 128'(pc_imm), 128'(16'h001F));
        chk("jal_wb", 128'({mreg_wb, mr7_wb}), 128'({2'd3, 2'd2}));

        send(16'h0030, 16'h62A5);
        for (int i = 0; i < 4; i++) begin
            chk("lm_wa", 128'(wA), 128'(wa_exp[i]));
            chk("lm_idx", 128'(uop_idx), 128'(i));
            chk("lm_last", 128'(uop_last), 128'(i == 3));
            if (i < 3) chk("lm_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk); #1;
        end

        send(16'h0040, 16'h7EFF);
        cnt = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            out_ready = (c % 3 != 1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("sm_idx", 128'(uop_idx), 128'(cnt));
                chk("sm_ra2", 128'(rA2), 128'(cnt));
                cnt++;
                if (uop_last) done = 1'b1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("sm_count", 128'(cnt), 128'(8));

        send(16'h0050, 16'h62A5);
        flush = 1'b1;
        #1 chk("flush_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        flush = 1'b0;
        #1 chk("flush_ready_after", 128'(in_ready), 128'(1));

        send(16'h0060, 16'hF123);
        chk("illegal_flag", 128'({out_valid, illegal}), 128'(2'b11));
        chk("illegal_bubble", 128'({wRF, wMem, wCCR, mmem_r}), 128'(4'b1110));
        @(posedge clk); #1;

        send(16'h0070, 16'h60FF);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_w_en", 128'({wRF, wMem, wCCR}), 128'(3'b111));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        send(16'h0080, 16'h0298);
        chk("post_rst_add", 128'({pc_out, rA1, uop_idx, uop_last}), 128'({16'h0080, 3'd1, 3'd0, 1'b1}));

        for (int c = 0; c < 3000; c++) begin
            rnd = $urandom;
            op  = 4'($urandom_range(0, 15));
            in_ir = {op, rnd[11:0]};
            if (op == 4'h6 || op == 4'h7) begin
                case ($urandom_range(0, 3))
                    0: in_ir[7:0] = 8'h00;
                    1: in_ir[7:0] = 8'hFF;
                    default: ;
                endcase
            end
            in_pc     = rnd[31:16];
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
